// File: rtl/cpu_pkg.sv
// Shared types for the memory sequencer: FSM states, access sizes and the
// default busy timeout.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_I_ISSUE,
    ST_I_WAIT,
    ST_D_ISSUE,
    ST_D_WAIT
  } seq_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } mem_size_t;

  localparam int TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and load extraction/extension for loads.
// The misalign flag also covers the illegal size encoding.
module mem_lane_align
  import cpu_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        zero_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [31:0] shifted;

  assign shifted = rdata >> {addr, 3'b000};

  always_comb begin
    sel        = 4'b0000;
    wdata_lane = '0;
    rdata_ext  = '0;
    misalign   = 1'b0;
    case (size)
      SZ_B: begin
        sel        = 4'b0001 << addr;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{shifted[7] & ~zero_ext}}, shifted[7:0]};
      end
      SZ_H: begin
        misalign   = addr[0];
        sel        = 4'b0011 << {addr[1], 1'b0};
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{shifted[15] & ~zero_ext}}, shifted[15:0]};
      end
      SZ_W: begin
        misalign   = |addr;
        sel        = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = shifted;
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_sequencer.sv
// Arbitrates the shared memory bus between instruction fetch and data
// load/store, one access in flight, with busy handshake and timeout.
module mem_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [31:0]       instr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  output logic              d_ready,
  output logic [31:0]       d_rdata,
  output logic              err,
  output logic              bus_read,
  output logic              bus_write,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [3:0]        bus_sel,
  input  logic              bus_busy,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam int TW = $clog2(TIMEOUT + 1);

  seq_state_t    state;
  logic [TW-1:0] timer;
  logic          acc_read;
  logic          acc_zext;
  logic [1:0]    acc_lane;
  logic [1:0]    acc_size;

  logic [1:0]    lane_addr;
  logic [1:0]    lane_size;
  logic          lane_zext;
  logic [3:0]    lane_sel;
  logic [31:0]   lane_wdata;
  logic [31:0]   lane_rdata;
  logic          lane_bad;

  logic          d_req;
  logic          i_take;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^i_addr[1:0];

  // A channel whose ready is pulsing is still finishing its handshake.
  assign d_req  = (d_read | d_write) & ~d_ready;
  assign i_take = i_req & ~i_ready;

  // In IDLE the aligner vets the incoming request; afterwards it extracts
  // load data using the attributes captured at acceptance.
  assign lane_addr = (state == ST_IDLE) ? d_addr[1:0] : acc_lane;
  assign lane_size = (state == ST_IDLE) ? d_size      : acc_size;
  assign lane_zext = (state == ST_IDLE) ? d_unsigned  : acc_zext;

  mem_lane_align u_lane (
    .addr       (lane_addr),
    .size       (lane_size),
    .zero_ext   (lane_zext),
    .wdata      (d_wdata),
    .rdata      (bus_rdata),
    .sel        (lane_sel),
    .wdata_lane (lane_wdata),
    .rdata_ext  (lane_rdata),
    .misalign   (lane_bad)
  );

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state     <= ST_IDLE;
      timer     <= '0;
      acc_read  <= 1'b0;
      acc_zext  <= 1'b0;
      acc_lane  <= 2'b00;
      acc_size  <= 2'b00;
      i_ready   <= 1'b0;
      instr     <= '0;
      d_ready   <= 1'b0;
      d_rdata   <= '0;
      err       <= 1'b0;
      bus_read  <= 1'b0;
      bus_write <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_sel   <= 4'b0000;
    end else begin
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
      err       <= 1'b0;
      bus_read  <= 1'b0;
      bus_write <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_sel   <= 4'b0000;
      case (state)
        ST_IDLE: begin
          if (d_req) begin
            if (lane_bad) begin
              d_ready <= 1'b1;
              err     <= 1'b1;
            end else begin
              state     <= ST_D_ISSUE;
              acc_read  <= d_read;
              acc_zext  <= d_unsigned;
              acc_lane  <= d_addr[1:0];
              acc_size  <= d_size;
              bus_read  <= d_read;
              bus_write <= ~d_read;
              bus_addr  <= {d_addr[ADDR_W-1:2], 2'b00};
              bus_sel   <= d_read ? 4'b1111 : lane_sel;
              bus_wdata <= d_read ? '0 : lane_wdata;
            end
          end else if (i_take) begin
            state    <= ST_I_ISSUE;
            bus_read <= 1'b1;
            bus_addr <= {i_addr[ADDR_W-1:2], 2'b00};
            bus_sel  <= 4'b1111;
          end
        end
        ST_I_ISSUE: begin
          timer <= '0;
          state <= ST_I_WAIT;
        end
        ST_D_ISSUE: begin
          timer <= '0;
          state <= ST_D_WAIT;
        end
        ST_I_WAIT, ST_D_WAIT: begin
          if (!bus_busy) begin
            state <= ST_IDLE;
            if (state == ST_I_WAIT) begin
              i_ready <= 1'b1;
              instr   <= bus_rdata;
            end else begin
              d_ready <= 1'b1;
              if (acc_read) d_rdata <= lane_rdata;
            end
          end else if (timer == TW'(TIMEOUT - 1)) begin
            state <= ST_IDLE;
            err   <= 1'b1;
            if (state == ST_I_WAIT) i_ready <= 1'b1;
            else                    d_ready <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_sequencer.md
Name: mem_sequencer

Overview:
- Sequences the single shared memory bus between instruction fetch and the data load/store path driven by the decoder's memRead/memWrite.
- Holds one access in flight at a time and handles the bus busy-handshake and a timeout.
- Does byte-lane steering for stores and load extraction/extension for LB/LH/LW/LBU/LHU and SB/SH/SW.
- Sits between the fetch/PC logic plus execute stage and the memory bus.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, bus data width (fixed at 32 for lane logic)
TIMEOUT, 64, max cycles in a WAIT state with bus_busy=1 before abort

Ports:
clk  in  1  system clock
nRst  in  1  reset, synchronous, active-low
i_req  in  1  fetch request, level, held until i_ready
i_addr  in  ADDR_W  fetch address
i_ready  out  1  one-cycle pulse, instr valid
instr  out  32  fetched word, registered
d_read  in  1  load request (decoder memRead), held until d_ready
d_write  in  1  store request (decoder memWrite), held until d_ready
d_addr  in  ADDR_W  byte address (ALU result)
d_wdata  in  32  store data (reg2)
d_size  in  2  00 byte, 01 half, 10 word, 11 illegal
d_unsigned  in  1  zero-extend load (LBU/LHU)
d_ready  out  1  one-cycle pulse, data access done
d_rdata  out  32  extended load result, registered
err  out  1  one-cycle pulse with ready on misalign/illegal size/timeout
bus_read  out  1  read strobe, one cycle
bus_write  out  1  write strobe, one cycle
bus_addr  out  ADDR_W  word-aligned {addr[31:2],2'b00}
bus_wdata  out  32  lane-steered store data
bus_sel  out  4  byte enables
bus_busy  in  1  memory busy
bus_rdata  in  32  read data, valid in first WAIT cycle with bus_busy=0

Behaviour:
- Reset (nRst=0 at a clk edge): state=IDLE, timer=0; all outputs 0, including instr and d_rdata. Reset aborts any in-flight access. Strobes are low from that edge.
- States: IDLE, I_ISSUE, I_WAIT, D_ISSUE, D_WAIT.
- IDLE, priority order:
  - (d_read|d_write) → D_ISSUE, unless the access is misaligned or illegal. That case stays IDLE and pulses d_ready+err next cycle with no bus access.
  - else i_req → I_ISSUE.
  - Data wins when both requests are present.
  - A channel whose ready is high this cycle is ignored in IDLE that cycle; requesters drop their request on ready.
- d_read and d_write both high: treated as read.
- ISSUE: exactly one cycle.
  - Strobe high; bus_addr/bus_sel/bus_wdata valid. I_ISSUE uses bus_sel=1111.
  - timer←0; go to WAIT.
- WAIT:
  - bus_busy=0: capture, state→IDLE, ready pulses next cycle with the registered data.
  - else timer++. If timer==TIMEOUT-1: state→IDLE, ready+err pulse next cycle, data outputs unchanged.
- Zero-wait latency: request seen in IDLE at cycle 0, ISSUE cycle 1, WAIT cycle 2, ready cycle 3. Back-to-back accesses every 3 cycles.
- Alignment: half needs addr[0]=0; word needs addr[1:0]=0.
- Store lanes:
  - byte: sel=0001<<a[1:0], wdata={4{w[7:0]}}.
  - half: sel=0011<<(2*a[1]), wdata={2{w[15:0]}}.
  - word: sel=1111, wdata=w.
- Load: shift rdata right by 8*a[1:0], keep 8/16/32 bits, sign-extend unless d_unsigned. Store completion leaves d_rdata unchanged.
- Outputs not being driven by an active strobe are 0.

Decomposition:
- cpu_pkg: seq_state_t enum (5 states), mem_size_t enum (SZ_B, SZ_H, SZ_W), TIMEOUT default constant.
- Sub-module: mem_lane_align, combinational. Inputs: addr[1:0], size, unsigned, wdata, rdata. Outputs: sel, steered wdata, extended rdata, misalign flag. The FSM, timer and registers stay in mem_sequencer.

Test Plan:
- Fetch, zero-wait: i_req=1, i_addr=0x100, bus_rdata=0x00500093 → bus_read at cycle 1 with bus_addr=0x100 and sel=1111; i_ready and instr=0x00500093 at cycle 3.
- Conflict: i_req and d_read (addr 0x203, size byte, signed) together, rdata=0x80FFFFFF → data first with sel=1111 and addr 0x200; d_rdata=0xFFFFFF80; fetch issues at cycle 4.
- Store half at 0x302, w=0x1234ABCD, busy 3 cycles → bus_write, sel=1100, wdata=0xABCDABCD; d_ready 4 cycles after WAIT entry; err=0.
- Misaligned word load at 0x401 → no bus strobe; d_ready+err at cycle 1; i_req then served normally.
- Timeout with TIMEOUT=4, bus_busy stuck at 1 → ready+err pulse after 4 WAIT cycles; the state returns to IDLE and accepts the next request.
- Reset mid-WAIT: nRst=0 for 1 cycle → all outputs 0 and the state is IDLE; no ready pulse is produced for the aborted access.
